exe_stage: RTL and testbench

//  Execute stage of the 5-stage pipelined MIPS CPU: sits between id_exe and exe_mem registers.

---
 rtl/exe_stage.sv | 210 +++++++++++++++++++++
 tb/tb_exe_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage: combinational ALU plus a 32-step iterative multiply/divide unit
// with HI/LO registers, raising exe_stall when a dependent op meets a busy unit.
module exe_stage #(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic [31:0] eimm,
  input  logic [3:0]  ealuc,
  input  logic        ealuimm,
  input  logic        eshift,
  input  logic [2:0]  emdop,
  input  logic [4:0]  ern,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  output logic [31:0] exe_alu,
  output logic [31:0] exe_b,
  output logic [4:0]  exe_rn,
  output logic        exe_z,
  output logic        exe_wreg,
  output logic        exe_m2reg,
  output logic        exe_wmem,
  output logic        exe_stall,
  output logic        exe_busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  localparam logic [4:0] LAST_STEP = 5'(MD_CYCLES - 1);

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MFHI  = 3'd5;
  localparam logic [2:0] MD_MFLO  = 3'd6;

  md_state_t   state_reg, state_next;
  logic [4:0]  count_reg, count_next;
  logic [63:0] prod_reg, prod_next;     // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [31:0] mcand_reg, mcand_next;   // multiplicand or divisor magnitude
  logic        div_reg, div_next;
  logic        neg_lo_reg, neg_lo_next;
  logic        neg_hi_reg, neg_hi_next;
  logic        dz_reg, dz_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;

  // ALU
  logic [31:0] alu_a, alu_b, alu_result;

  always_comb begin
    alu_a = eshift ? {27'b0, eimm[10:6]} : ea;
    alu_b = ealuimm ? eimm : eb;
    case (ealuc)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a & alu_b;
      4'd3:    alu_result = alu_a | alu_b;
      4'd4:    alu_result = alu_a ^ alu_b;
      4'd5:    alu_result = ~(alu_a | alu_b);
      4'd6:    alu_result = {alu_b[15:0], 16'b0};
      4'd7:    alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'd8:    alu_result = {31'b0, alu_a < alu_b};
      4'd9:    alu_result = alu_b << alu_a[4:0];
      4'd10:   alu_result = alu_b >> alu_a[4:0];
      4'd11:   alu_result = $signed(alu_b) >>> alu_a[4:0];
      default: alu_result = 32'b0;
    endcase
  end

  // Issue decode
  logic is_md, md_signed, md_div, md_start;
  logic [31:0] mag_a, mag_b;

  assign is_md     = (emdop == MD_MULT) || (emdop == MD_MULTU) ||
                     (emdop == MD_DIV)  || (emdop == MD_DIVU);
  assign md_signed = (emdop == MD_MULT) || (emdop == MD_DIV);
  assign md_div    = (emdop == MD_DIV)  || (emdop == MD_DIVU);
  assign mag_a     = (md_signed && ea[31]) ? -ea : ea;
  assign mag_b     = (md_signed && eb[31]) ? -eb : eb;

  assign exe_busy  = (state_reg != IDLE);
  assign exe_stall = exe_busy && (emdop != 3'd0);
  assign md_start  = (state_reg == IDLE) && is_md && !exe_stall;

  // One iteration: shift-add for multiply, restoring shift-subtract for divide
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_step;

  always_comb begin
    mul_sum   = {1'b0, prod_reg[63:32]} + {1'b0, (prod_reg[0] ? mcand_reg : 32'b0)};
    mul_step  = {mul_sum, prod_reg[31:1]};
    div_shift = {prod_reg[63:32], prod_reg[31]};
    div_diff  = div_shift - {1'b0, mcand_reg};
    if (div_diff[32])
      div_step = {div_shift[31:0], prod_reg[30:0], 1'b0};
    else
      div_step = {div_diff[31:0], prod_reg[30:0], 1'b1};
  end

  // Sign correction of the raw magnitude result
  logic [63:0] prod_fixed;
  logic [31:0] quo_fixed, rem_fixed;

  always_comb begin
    prod_fixed = neg_lo_reg ? -prod_reg : prod_reg;
    quo_fixed  = dz_reg ? 32'hFFFF_FFFF : (neg_lo_reg ? -prod_reg[31:0] : prod_reg[31:0]);
    rem_fixed  = neg_hi_reg ? -prod_reg[63:32] : prod_reg[63:32];
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    prod_next   = prod_reg;
    mcand_next  = mcand_reg;
    div_next    = div_reg;
    neg_lo_next = neg_lo_reg;
    neg_hi_next = neg_hi_reg;
    dz_next     = dz_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    case (state_reg)
      IDLE: begin
        if (md_start) begin
          state_next  = BUSY;
          count_next  = 5'd0;
          div_next    = md_div;
          neg_lo_next = md_signed && (ea[31] ^ eb[31]);
          neg_hi_next = md_signed && ea[31];
          dz_next     = (eb == 32'b0);
          if (md_div) begin
            prod_next  = {32'b0, mag_a};
            mcand_next = mag_b;
          end else begin
            prod_next  = {32'b0, mag_b};
            mcand_next = mag_a;
          end
        end
      end
      BUSY: begin
        prod_next  = div_reg ? div_step : mul_step;
        count_next = count_reg + 5'd1;
        if (count_reg == LAST_STEP)
          state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
        count_next = 5'd0;
        if (div_reg) begin
          hi_next = rem_fixed;
          lo_next = quo_fixed;
        end else begin
          hi_next = prod_fixed[63:32];
          lo_next = prod_fixed[31:0];
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg  <= IDLE;
      count_reg  <= 5'd0;
      prod_reg   <= 64'b0;
      mcand_reg  <= 32'b0;
      div_reg    <= 1'b0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      dz_reg     <= 1'b0;
      hi_reg     <= 32'b0;
      lo_reg     <= 32'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      prod_reg   <= prod_next;
      mcand_reg  <= mcand_next;
      div_reg    <= div_next;
      neg_lo_reg <= neg_lo_next;
      neg_hi_reg <= neg_hi_next;
      dz_reg     <= dz_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
    end
  end

  // Result and control out to exe_mem; a stall squashes the instruction into a bubble
  always_comb begin
    if (emdop == MD_MFHI)
      exe_alu = hi_reg;
    else if (emdop == MD_MFLO)
      exe_alu = lo_reg;
    else
      exe_alu = alu_result;
  end

  assign exe_z     = (exe_alu == 32'b0);
  assign exe_b     = eb;
  assign exe_rn    = ern;
  assign exe_wreg  = ewreg  && !exe_stall && !is_md;
  assign exe_wmem  = ewmem  && !exe_stall && !is_md;
  assign exe_m2reg = em2reg && !exe_stall;

endmodule

// File: tb/tb_exe_stage.sv
// Randomized scoreboard bench for exe_stage: the driver pushes expected outputs from a
// cycle-count/arithmetic reference model; a negedge monitor pops and compares.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] ea, eb, eimm;
  logic [3:0]  ealuc;
  logic        ealuimm, eshift;
  logic [2:0]  emdop;
  logic [4:0]  ern;
  logic        ewreg, em2reg, ewmem;
  logic [31:0] exe_alu, exe_b;
  logic [4:0]  exe_rn;
  logic        exe_z, exe_wreg, exe_m2reg, exe_wmem, exe_stall, exe_busy;

  exe_stage #(.MD_CYCLES(32)) dut (
    .clk(clk), .clrn(clrn), .ea(ea), .eb(eb), .eimm(eimm), .ealuc(ealuc),
    .ealuimm(ealuimm), .eshift(eshift), .emdop(emdop), .ern(ern),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .exe_alu(exe_alu), .exe_b(exe_b), .exe_rn(exe_rn), .exe_z(exe_z),
    .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_wmem(exe_wmem),
    .exe_stall(exe_stall), .exe_busy(exe_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  rn;
    logic        z, wreg, m2reg, wmem, stall, busy;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state: committed HI/LO and a pending result with its busy window
  logic [31:0] hi_m, lo_m, pend_hi, pend_lo;
  bit          pend_v = 1'b0;
  int          busy_until = 0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return b * 32'd65536;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:    return (a < b) ? 32'd1 : 32'd0;
      4'd9:    return b << a[4:0];
      4'd10:   return b >> a[4:0];
      4'd11:   return $signed(b) >>> a[4:0];
      default: return 32'd0;
    endcase
  endfunction

  task automatic ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    hi = 32'b0;
    lo = 32'b0;
    case (op)
      3'd1: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      3'd2: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      3'd3: begin
        if (b == 32'b0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
      end
      3'd4: begin
        if (b == 32'b0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
      end
      default: ;
    endcase
  endtask

  task automatic apply(input string tag, input logic [2:0] mdop, input logic [3:0] aluc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input bit aluimm, input bit shift, input bit wreg, input bit m2reg,
                       input bit wmem, input logic [4:0] rn, input bit rst_low);
    exp_t e;
    bit busy, stall, md;
    logic [31:0] opa, opb;
    @(posedge clk);
    #1;
    clrn = !rst_low;
    ea = a; eb = b; eimm = imm; ealuc = aluc; ealuimm = aluimm; eshift = shift;
    emdop = mdop; ern = rn; ewreg = wreg; em2reg = m2reg; ewmem = wmem;
    if (rst_low) begin
      hi_m = 32'b0; lo_m = 32'b0; pend_v = 1'b0;
    end else if (pend_v && cyc > busy_until) begin
      hi_m = pend_hi; lo_m = pend_lo; pend_v = 1'b0;
    end
    busy  = pend_v && (cyc <= busy_until);
    stall = busy && (mdop != 3'd0);
    md    = (mdop >= 3'd1) && (mdop <= 3'd4);
    if (!rst_low && !busy && md) begin
      ref_md(mdop, a, b, pend_hi, pend_lo);
      pend_v = 1'b1;
      busy_until = cyc + 33;
    end
    opa = shift ? {27'b0, imm[10:6]} : a;
    opb = aluimm ? imm : b;
    if (mdop == 3'd5)      e.alu = hi_m;
    else if (mdop == 3'd6) e.alu = lo_m;
    else                   e.alu = ref_alu(aluc, opa, opb);
    e.z     = (e.alu == 32'b0);
    e.b     = b;
    e.rn    = rn;
    e.wreg  = wreg && !stall && !md;
    e.wmem  = wmem && !stall && !md;
    e.m2reg = m2reg && !stall;
    e.stall = stall;
    e.busy  = busy;
    e.tag   = tag;
    exp_q.push_back(e);
  endtask

  task automatic alu_op(input string tag, input logic [3:0] aluc, input logic [31:0] a, input logic [31:0] b);
    apply(tag, 3'd0, aluc, a, b, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0);
  endtask

  task automatic md_op(input string tag, input logic [2:0] mdop, input logic [31:0] a, input logic [31:0] b);
    apply(tag, mdop, 4'd0, a, b, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0);
  endtask

  task automatic rand_vec();
    int r;
    logic [2:0] md;
    logic [31:0] a, b;
    r = $urandom_range(0, 19);
    if (r < 12)      md = 3'd0;
    else if (r < 16) md = 3'($urandom_range(1, 4));
    else             md = 3'($urandom_range(5, 6));
    a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
    b = ($urandom_range(0, 7) == 0) ? 32'h0 : (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom);
    apply("rand", md, 4'($urandom_range(0, 15)), a, b, $urandom,
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          5'($urandom), 1'b0);
  endtask

  // Monitor: outputs are combinational, sampled at the falling edge of each driven cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (exe_alu !== e.alu || exe_z !== e.z || exe_b !== e.b || exe_rn !== e.rn ||
          exe_wreg !== e.wreg || exe_m2reg !== e.m2reg || exe_wmem !== e.wmem ||
          exe_stall !== e.stall || exe_busy !== e.busy) begin
        n_bad++;
        $display("FAIL %s vec %0d: got alu=%h z=%b b=%h rn=%0d wreg=%b m2reg=%b wmem=%b stall=%b busy=%b; want alu=%h z=%b b=%h rn=%0d wreg=%b m2reg=%b wmem=%b stall=%b busy=%b",
                 e.tag, n_vec, exe_alu, exe_z, exe_b, exe_rn, exe_wreg, exe_m2reg, exe_wmem, exe_stall, exe_busy,
                 e.alu, e.z, e.b, e.rn, e.wreg, e.m2reg, e.wmem, e.stall, e.busy);
      end else begin
        $display("vec %0d %s ok alu=%h stall=%b busy=%b", n_vec, e.tag, exe_alu, exe_stall, exe_busy);
      end
    end
  end

  initial begin
    clrn = 1'b0; ea = '0; eb = '0; eimm = '0; ealuc = '0; ealuimm = 1'b0; eshift = 1'b0;
    emdop = '0; ern = '0; ewreg = 1'b0; em2reg = 1'b0; ewmem = 1'b0;
    hi_m = '0; lo_m = '0; pend_hi = '0; pend_lo = '0;

    // Reset state: mfhi under reset reads zero, unit idle
    apply("reset", 3'd5, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1);
    apply("reset_mflo", 3'd6, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1);

    // Directed ALU cases
    alu_op("add_wrap", 4'd0, 32'h7FFF_FFFF, 32'h1);
    alu_op("sub_zero", 4'd1, 32'd5, 32'd5);
    apply("sra_shamt", 3'd0, 4'd11, 32'h1234_5678, 32'hF000_0000, 32'h0000_0100,
          1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 1'b0);
    alu_op("slt", 4'd7, 32'hFFFF_FFFF, 32'h1);
    alu_op("sltu", 4'd8, 32'hFFFF_FFFF, 32'h1);
    apply("lui", 3'd0, 4'd6, 32'h0, 32'h0, 32'h0000_ABCD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0);
    alu_op("nor", 4'd5, 32'h0F0F_0000, 32'h0000_F0F0);
    alu_op("op15", 4'd15, 32'h1, 32'h2);

    // mult -3*7 followed by a dependent mflo that stalls until the result lands
    md_op("mult", 3'd1, 32'hFFFF_FFFD, 32'd7);
    for (int i = 0; i < 34; i++) md_op("mflo_wait", 3'd6, 32'h0, 32'h0);
    md_op("mfhi", 3'd5, 32'h0, 32'h0);

    // div -7/2 and divu 9/0, with unrelated ALU traffic during the busy window
    md_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 33; i++) alu_op("add_bg", 4'd0, $urandom, $urandom);
    md_op("mflo", 3'd6, 32'h0, 32'h0);
    md_op("mfhi", 3'd5, 32'h0, 32'h0);
    md_op("divu0", 3'd4, 32'd9, 32'd0);
    apply("sw_bg", 3'd0, 4'd0, 32'h100, 32'hDEAD_BEEF, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
    md_op("mult_stall", 3'd1, 32'd3, 32'd4);
    for (int i = 0; i < 31; i++) alu_op("or_bg", 4'd3, $urandom, $urandom);
    md_op("mult_in_done", 3'd2, 32'd5, 32'd6);
    md_op("mflo", 3'd6, 32'h0, 32'h0);
    md_op("mfhi", 3'd5, 32'h0, 32'h0);

    // Reset in the middle of a multu (count 15)
    md_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 15; i++) alu_op("and_bg", 4'd2, $urandom, $urandom);
    apply("mid_reset", 3'd5, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1);
    md_op("mfhi_after", 3'd5, 32'h0, 32'h0);
    md_op("mflo_after", 3'd6, 32'h0, 32'h0);

    for (int i = 0; i < 400; i++) rand_vec();
    for (int i = 0; i < 40; i++) md_op("drain", 3'd0, $urandom, $urandom);
    md_op("final_mfhi", 3'd5, 32'h0, 32'h0);
    md_op("final_mflo", 3'd6, 32'h0, 32'h0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
